// File: rtl/camera_capture_packed.sv
// Camera capture: picks luma out of the byte stream, thresholds it, optionally
// decimates, and packs kept pixels LSB-first into PACK_W-bit memory words.
module camera_capture_packed #(
  parameter int IMG_W         = 320,
  parameter int IMG_H         = 240,
  parameter int PACK_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int Y_IDX         = 0,
  parameter int DECIM_LOG2    = 0,
  parameter int ADDR_W        = 17
) (
  input  logic              cam_pclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic [7:0]        threshold,
  input  logic              invert,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PACK_W-1:0] wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);
  localparam int WPL = (IMG_W >> DECIM_LOG2) / PACK_W;
  localparam int XW  = $clog2(IMG_W + 1);
  localparam int YW  = $clog2(IMG_H + 2);
  localparam int PW  = $clog2(BYTES_PER_PIX + 1);
  localparam int BW  = (PACK_W > 1) ? $clog2(PACK_W) : 1;
  localparam int WW  = $clog2(WPL + 1);

  localparam logic [XW-1:0] X_MAX   = XW'(IMG_W);
  localparam logic [YW-1:0] Y_MAX   = YW'(IMG_H);
  localparam logic [YW-1:0] Y_SAT   = YW'(IMG_H + 1);
  localparam logic [PW-1:0] P_LAST  = PW'(BYTES_PER_PIX - 1);
  localparam logic [PW-1:0] P_Y     = PW'(Y_IDX);
  localparam logic [BW-1:0] B_LAST  = BW'(PACK_W - 1);
  localparam logic [XW-1:0] X_DMASK = XW'((1 << DECIM_LOG2) - 1);
  localparam logic [YW-1:0] Y_DMASK = YW'((1 << DECIM_LOG2) - 1);

  if (DECIM_LOG2 < 0 || DECIM_LOG2 > 2 || ((IMG_W >> DECIM_LOG2) % PACK_W) != 0 ||
      Y_IDX < 0 || Y_IDX >= BYTES_PER_PIX) begin : g_param_chk
    $error("camera_capture_packed: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
  state_t state, state_nxt;

  logic              vsync_q, href_q, line_act;
  logic [PW-1:0]     phase;
  logic [XW-1:0]     pix_cnt;
  logic [YW-1:0]     line_cnt, cur_y;
  logic [ADDR_W-1:0] line_base;
  logic [WW-1:0]     wcnt;
  logic [BW-1:0]     bcnt;
  logic [PACK_W-1:0] sh;

  logic              vs_rise, vs_fall, h_rise, h_fall, cap, h_rise_c, byte_v;
  logic              luma, line_ok, keep, pix_bit, flush, err_set;
  logic [PW-1:0]     ph_eff;
  logic [XW-1:0]     px_eff;
  logic [YW-1:0]     y_eff;
  logic [BW-1:0]     bc_eff;
  logic [WW-1:0]     wc_eff;
  logic [ADDR_W-1:0] base_eff;
  logic [PACK_W-1:0] word;

  always_ff @(posedge cam_pclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && cam_vsync) state_nxt = ARMED;
      ARMED:   if (vs_fall)             state_nxt = CAPTURE;
      CAPTURE: if (vs_rise)             state_nxt = enable ? ARMED : IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // On an href rising edge the per-line counters read as zero for the byte
  // arriving on that same edge.
  always_comb begin
    vs_rise  = cam_vsync & ~vsync_q;
    vs_fall  = ~cam_vsync & vsync_q;
    h_rise   = cam_href & ~href_q;
    h_fall   = ~cam_href & href_q;
    cap      = (state == CAPTURE);
    h_rise_c = cap & ~cam_vsync & h_rise;
    byte_v   = cap & ~cam_vsync & cam_href & (line_act | h_rise_c);
    ph_eff   = h_rise_c ? '0 : phase;
    px_eff   = h_rise_c ? '0 : pix_cnt;
    bc_eff   = h_rise_c ? '0 : bcnt;
    wc_eff   = h_rise_c ? '0 : wcnt;
    y_eff    = h_rise_c ? line_cnt : cur_y;
    base_eff = h_rise_c ? ADDR_W'((line_cnt >> DECIM_LOG2) * WPL) : line_base;
    line_ok  = (y_eff < Y_MAX);
    luma     = byte_v & (ph_eff == P_Y);
    keep     = luma & line_ok & (px_eff < X_MAX) &
               ((px_eff & X_DMASK) == '0) & ((y_eff & Y_DMASK) == '0);
    pix_bit  = (cam_data >= threshold) ^ invert;
    word     = sh;
    word[bc_eff] = pix_bit;
    flush    = keep & (bc_eff == B_LAST);
    // Short-line check uses the pre-edge counters so a line ending on the
    // same edge as vsync rising is still judged before frame_done.
    err_set  = (luma & line_ok & (px_eff == X_MAX))
             | (h_rise_c & (line_cnt >= Y_MAX))
             | (cap & h_fall & line_act & (cur_y < Y_MAX) & (pix_cnt < X_MAX))
             | (cap & vs_rise & (line_cnt != Y_MAX));
  end

  always_ff @(posedge cam_pclk) begin
    if (reset) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      line_act   <= 1'b0;
      phase      <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      cur_y      <= '0;
      line_base  <= '0;
      wcnt       <= '0;
      bcnt       <= '0;
      sh         <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      vsync_q    <= cam_vsync;
      href_q     <= cam_href;
      wr_en      <= flush;
      frame_done <= cap & vs_rise;
      if (flush) begin
        wr_data <= word;
        wr_addr <= base_eff + ADDR_W'(wc_eff);
      end
      if (vs_fall)      frame_err <= 1'b0;
      else if (err_set) frame_err <= 1'b1;

      if (!cap) begin
        line_cnt <= '0;
        line_act <= 1'b0;
      end else if (h_rise_c) begin
        line_act  <= 1'b1;
        cur_y     <= line_cnt;
        line_base <= base_eff;
        if (line_cnt != Y_SAT) line_cnt <= line_cnt + YW'(1);
      end else if (h_fall) begin
        line_act <= 1'b0;
      end

      if (byte_v) phase <= (ph_eff == P_LAST) ? '0 : ph_eff + PW'(1);

      if (luma && px_eff != X_MAX) pix_cnt <= px_eff + XW'(1);
      else if (h_rise_c)           pix_cnt <= '0;

      if (keep) begin
        bcnt <= flush ? '0 : bc_eff + BW'(1);
        sh   <= word;
      end else if (h_rise_c) begin
        bcnt <= '0;
      end

      if (flush)         wcnt <= wc_eff + WW'(1);
      else if (h_rise_c) wcnt <= '0;
    end
  end

  assign busy = cap;

endmodule

// File: tb/tb_camera_capture_packed.sv
// Bench for camera_capture_packed: two geometries driven from one stimulus
// stream, checked against a frame-level reference model.
module tb_camera_capture_packed;
  logic cam_pclk = 1'b0;
  always #5 cam_pclk = ~cam_pclk;

  logic        reset, enable, cam_vsync, cam_href, invert;
  logic [7:0]  cam_data, threshold;
  logic [16:0] wr_addr_a, wr_addr_b;
  logic [7:0]  wr_data_a, wr_data_b;
  logic        wr_en_a, wr_en_b, frame_done_a, frame_done_b;
  logic        frame_err_a, frame_err_b, busy_a, busy_b;

  camera_capture_packed #(.IMG_W(16), .IMG_H(2), .PACK_W(8), .BYTES_PER_PIX(2),
    .Y_IDX(0), .DECIM_LOG2(0), .ADDR_W(17)) dut_a (
    .cam_pclk(cam_pclk), .reset(reset), .enable(enable), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .threshold(threshold), .invert(invert),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a),
    .frame_done(frame_done_a), .frame_err(frame_err_a), .busy(busy_a));

  camera_capture_packed #(.IMG_W(32), .IMG_H(4), .PACK_W(8), .BYTES_PER_PIX(2),
    .Y_IDX(0), .DECIM_LOG2(1), .ADDR_W(17)) dut_b (
    .cam_pclk(cam_pclk), .reset(reset), .enable(enable), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .threshold(threshold), .invert(invert),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b),
    .frame_done(frame_done_b), .frame_err(frame_err_b), .busy(busy_b));

  int total = 0;
  int bad   = 0;
  logic [24:0] mon_a[$], mon_b[$], exp_q[$];
  int   done_a, done_b;
  logic err_a, err_b, exp_err;

  logic [7:0] pix [0:7][0:63];
  int         len [0:7];
  int         nl;

  always @(negedge cam_pclk) begin
    if (wr_en_a) mon_a.push_back({wr_addr_a, wr_data_a});
    if (wr_en_b) mon_b.push_back({wr_addr_b, wr_data_b});
    if (frame_done_a) begin done_a++; err_a = frame_err_a; end
    if (frame_done_b) begin done_b++; err_b = frame_err_b; end
  end

  task automatic tick();
    @(negedge cam_pclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_wr_en"},  32'(wr_en_a), 32'd0);
    chk({tag, "_done"},   32'(frame_done_a), 32'd0);
    chk({tag, "_err"},    32'(frame_err_a), 32'd0);
    chk({tag, "_busy"},   32'(busy_a), 32'd0);
    chk({tag, "_addr"},   32'(wr_addr_a), 32'd0);
    chk({tag, "_data"},   32'(wr_data_a), 32'd0);
    chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
  endtask

  task automatic set_alt(input int w, input int n, input logic [7:0] ya, input logic [7:0] yb);
    nl = n;
    for (int y = 0; y < 8; y++) begin
      len[y] = w;
      for (int x = 0; x < 64; x++) pix[y][x] = x[0] ? yb : ya;
    end
  endtask

  // Expected writes and error flag straight from the frame description.
  task automatic model(input int w, input int h, input int d);
    int nk, wpl, step;
    logic [7:0] word;
    exp_q.delete();
    exp_err = (nl != h);
    wpl  = (w >> d) / 8;
    step = 1 << d;
    for (int y = 0; y < nl; y++) begin
      if (y >= h) begin exp_err = 1'b1; continue; end
      if (len[y] != w) exp_err = 1'b1;
      if (y % step != 0) continue;
      nk = 0;
      word = 8'h00;
      for (int x = 0; x < len[y] && x < w; x++) begin
        if (x % step == 0) begin
          word[3'(nk % 8)] = (pix[y][x] >= threshold) ^ invert;
          nk++;
          if (nk % 8 == 0) exp_q.push_back({17'((y >> d) * wpl + nk / 8 - 1), word});
        end
      end
    end
  endtask

  task automatic drive_frame(input int rst_px, input int en_drop_line, input bit sim_end);
    mon_a.delete(); mon_b.delete();
    done_a = 0; done_b = 0; err_a = 1'b0; err_b = 1'b0;
    cam_vsync = 1'b1; cam_href = 1'b0;
    repeat (4) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
    for (int y = 0; y < nl; y++) begin
      if (y == en_drop_line) enable = 1'b0;
      cam_href = 1'b1;
      for (int x = 0; x < len[y]; x++) begin
        for (int b = 0; b < 2; b++) begin
          cam_data = (b == 0) ? pix[y][x] : 8'($urandom);
          if (y == 0 && x == rst_px && b == 0) reset = 1'b1;
          tick();
          if (reset) begin
            reset = 1'b0;
            rst_checks("midrst");
          end
        end
      end
      cam_href = 1'b0;
      if (sim_end && y == nl - 1) cam_vsync = 1'b1;
      repeat (4) tick();
    end
    cam_vsync = 1'b1;
    repeat (6) tick();
  endtask

  task automatic check_frame(input bit inst_b, input string tag);
    logic [24:0] got[$];
    if (inst_b) got = mon_b; else got = mon_a;
    chk({tag, "_nwr"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    chk({tag, "_done"}, 32'(inst_b ? done_b : done_a), 32'd1);
    chk({tag, "_err"},  32'(inst_b ? err_b : err_a), 32'(exp_err));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0;
    cam_data = 8'h00; threshold = 8'd128; invert = 1'b0;
    repeat (3) tick();
    rst_checks("init");
    reset = 1'b0;

    set_alt(16, 2, 8'd50, 8'd200); model(16, 2, 0);
    drive_frame(-1, -1, 1'b0); check_frame(1'b0, "alt");

    invert = 1'b1; model(16, 2, 0);
    drive_frame(-1, -1, 1'b0); check_frame(1'b0, "inv");

    invert = 1'b0; set_alt(16, 2, 8'd128, 8'd128); model(16, 2, 0);
    drive_frame(-1, -1, 1'b0); check_frame(1'b0, "eq_thr");

    set_alt(32, 4, 8'd50, 8'd200); model(32, 4, 1);
    drive_frame(-1, -1, 1'b0); check_frame(1'b1, "decim");

    set_alt(16, 2, 8'd50, 8'd200); len[0] = 8; model(16, 2, 0);
    drive_frame(-1, -1, 1'b0); check_frame(1'b0, "cut");
    chk("cut_err_hold", 32'(frame_err_a), 32'd1);

    set_alt(16, 2, 8'd50, 8'd200); len[1] = 10; model(16, 2, 0);
    drive_frame(-1, -1, 1'b1); check_frame(1'b0, "simend");

    set_alt(16, 2, 8'd50, 8'd200);
    drive_frame(5, -1, 1'b0);
    chk("rstmid_nwr",  32'(mon_a.size()), 32'd0);
    chk("rstmid_done", 32'(done_a), 32'd0);
    model(16, 2, 0);
    drive_frame(-1, -1, 1'b0); check_frame(1'b0, "after_rst");

    set_alt(16, 3, 8'd50, 8'd200); model(16, 2, 0);
    drive_frame(-1, 1, 1'b0); check_frame(1'b0, "endrop");
    chk("endrop_busy", 32'(busy_a), 32'd0);
    set_alt(16, 2, 8'd50, 8'd200);
    drive_frame(-1, -1, 1'b0);
    chk("idle_nwr",  32'(mon_a.size()), 32'd0);
    chk("idle_done", 32'(done_a), 32'd0);
    enable = 1'b1;

    for (int k = 0; k < 8; k++) begin
      int w, h, d;
      bit ib;
      ib = k[0];
      w  = ib ? 32 : 16;
      h  = ib ? 4 : 2;
      d  = ib ? 1 : 0;
      threshold = 8'($urandom);
      invert    = 1'($urandom);
      nl = $urandom_range(1, h + 1);
      for (int y = 0; y < nl; y++) begin
        case ($urandom_range(0, 3))
          0:       len[y] = w - 3;
          1:       len[y] = w + 4;
          default: len[y] = w;
        endcase
        for (int x = 0; x < len[y]; x++) pix[y][x] = 8'($urandom);
      end
      model(w, h, d);
      drive_frame(-1, -1, 1'b0);
      check_frame(ib, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
